// File: rtl/cpu_pkg.sv
// Shared semi-CPU definitions: instruction memory geometry and loader state encoding.
package cpu_pkg;

   localparam int unsigned IM_ADDR_W = 5;
   localparam int unsigned IM_DEPTH  = 32;

   localparam logic [2:0] LD_IDLE  = 3'd0;
   localparam logic [2:0] LD_COUNT = 3'd1;
   localparam logic [2:0] LD_DATA  = 3'd2;
   localparam logic [2:0] LD_CHECK = 3'd3;
   localparam logic [2:0] LD_DONE  = 3'd4;
   localparam logic [2:0] LD_ERROR = 3'd5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampling tick, mid-bit sampling.
module uart_rx #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam int unsigned DIV   = (CLK_HZ / (BAUD * 16) > 0) ? CLK_HZ / (BAUD * 16) : 1;
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;

   logic [1:0]       sync;
   logic             rx_s;
   logic [2:0]       st, st_nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [3:0]       os_cnt, os_nxt;
   logic [2:0]       bit_cnt, bit_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [7:0]       data_nxt;
   logic             valid_nxt, ferr_nxt;
   logic             tick;

   assign rx_s = sync[1];
   assign tick = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync     <= 2'b11;
         st       <= S_IDLE;
         div_cnt  <= '0;
         os_cnt   <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         sync     <= {sync[0], rx};
         st       <= st_nxt;
         div_cnt  <= div_nxt;
         os_cnt   <= os_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= shreg_nxt;
         rx_data  <= data_nxt;
         rx_valid <= valid_nxt;
         rx_ferr  <= ferr_nxt;
      end
   end

   // Bit sampler: start re-checked at mid-bit, data/stop sampled every 16 ticks after
   always_comb begin
      st_nxt    = st;
      div_nxt   = tick ? '0 : div_cnt + DIV_W'(1);
      os_nxt    = tick ? os_cnt + 4'd1 : os_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      data_nxt  = rx_data;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (st)
         S_IDLE: begin
            if (!rx_s) begin
               st_nxt  = S_START;
               os_nxt  = '0;
               div_nxt = '0;
            end
         end
         S_START: begin
            if (tick && os_cnt == 4'd7) begin
               os_nxt  = '0;
               bit_nxt = '0;
               st_nxt  = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick && os_cnt == 4'd15) begin
               shreg_nxt = {rx_s, shreg[7:1]};
               if (bit_cnt == 3'd7) st_nxt = S_STOP;
               else                 bit_nxt = bit_cnt + 3'd1;
            end
         end
         S_STOP: begin
            if (tick && os_cnt == 4'd15) begin
               if (rx_s) begin
                  valid_nxt = 1'b1;
                  data_nxt  = shreg;
                  st_nxt    = S_IDLE;
               end else begin
                  ferr_nxt = 1'b1;
                  st_nxt   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // a low stop bit must not be mistaken for the next start bit
            if (rx_s) st_nxt = S_IDLE;
         end
         default: st_nxt = S_IDLE;
      endcase
   end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: framed UART bytes -> 32-bit words written into instruction memory.
module program_loader
   import cpu_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 115200,
   parameter int unsigned ADDR_W = IM_ADDR_W,
   parameter int unsigned DEPTH  = IM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic              load_start,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_waddr,
   output logic [31:0]       im_wdata,
   output logic              loading,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

   logic [7:0]        rx_data;
   logic              rx_valid, rx_ferr;
   logic [2:0]        state, state_nxt;
   logic [CNT_W-1:0]  n_words, n_words_nxt;
   logic [1:0]        byte_k, byte_k_nxt;
   logic [23:0]       word_buf, word_buf_nxt;
   logic [7:0]        chk_acc, chk_acc_nxt;
   logic [CNT_W-1:0]  wc_nxt, wc_inc;
   logic              we_nxt, loading_nxt, done_nxt, err_nxt;
   logic [ADDR_W-1:0] waddr_nxt;
   logic [31:0]       wdata_nxt;

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_uart_rx (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   assign wc_inc = word_count + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LD_IDLE;
         n_words    <= '0;
         byte_k     <= '0;
         word_buf   <= '0;
         chk_acc    <= '0;
         word_count <= '0;
         im_we      <= 1'b0;
         im_waddr   <= '0;
         im_wdata   <= '0;
         loading    <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         n_words    <= n_words_nxt;
         byte_k     <= byte_k_nxt;
         word_buf   <= word_buf_nxt;
         chk_acc    <= chk_acc_nxt;
         word_count <= wc_nxt;
         im_we      <= we_nxt;
         im_waddr   <= waddr_nxt;
         im_wdata   <= wdata_nxt;
         loading    <= loading_nxt;
         load_done  <= done_nxt;
         load_err   <= err_nxt;
      end
   end

   // Framing FSM and word packer; load_start overrides everything, including a same-cycle byte
   always_comb begin
      state_nxt    = state;
      n_words_nxt  = n_words;
      byte_k_nxt   = byte_k;
      word_buf_nxt = word_buf;
      chk_acc_nxt  = chk_acc;
      wc_nxt       = word_count;
      we_nxt       = 1'b0;
      waddr_nxt    = im_waddr;
      wdata_nxt    = im_wdata;
      loading_nxt  = loading;
      done_nxt     = load_done;
      err_nxt      = load_err;
      if (load_start) begin
         state_nxt    = LD_COUNT;
         byte_k_nxt   = '0;
         word_buf_nxt = '0;
         chk_acc_nxt  = '0;
         wc_nxt       = '0;
         loading_nxt  = 1'b1;
         done_nxt     = 1'b0;
         err_nxt      = 1'b0;
      end else begin
         case (state)
            LD_COUNT: begin
               if (rx_ferr) state_nxt = LD_ERROR;
               else if (rx_valid) begin
                  if (rx_data == 8'd0 || rx_data > DEPTH_B) state_nxt = LD_ERROR;
                  else begin
                     n_words_nxt = CNT_W'(rx_data);
                     state_nxt   = LD_DATA;
                  end
               end
            end
            LD_DATA: begin
               if (rx_ferr) state_nxt = LD_ERROR;
               else if (rx_valid) begin
                  chk_acc_nxt = chk_acc ^ rx_data;
                  byte_k_nxt  = byte_k + 2'd1;
                  case (byte_k)
                     2'd0: word_buf_nxt[7:0]   = rx_data;
                     2'd1: word_buf_nxt[15:8]  = rx_data;
                     2'd2: word_buf_nxt[23:16] = rx_data;
                     default: begin
                        we_nxt    = 1'b1;
                        waddr_nxt = word_count[ADDR_W-1:0];
                        wdata_nxt = {rx_data, word_buf};
                        wc_nxt    = wc_inc;
                        if (wc_inc == n_words) state_nxt = LD_CHECK;
                     end
                  endcase
               end
            end
            LD_CHECK: begin
               if (rx_ferr) state_nxt = LD_ERROR;
               else if (rx_valid) state_nxt = (rx_data == chk_acc) ? LD_DONE : LD_ERROR;
            end
            default: ;
         endcase
         if (state_nxt == LD_DONE) begin
            loading_nxt = 1'b0;
            done_nxt    = 1'b1;
         end
         if (state_nxt == LD_ERROR) begin
            loading_nxt = 1'b0;
            err_nxt     = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed bench for program_loader against a frame-level reference model.
module tb_program_loader;

   localparam int unsigned BIT_CLKS = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        load_start = 1'b0;
   logic        im_we;
   logic [4:0]  im_waddr;
   logic [31:0] im_wdata;
   logic        loading, load_done, load_err;
   logic [5:0]  word_count;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: phase 0 idle, 1 count, 2 data, 3 check, 4 done, 5 error
   int         m_phase = 0;
   int         m_n = 0;
   logic [7:0] m_data[$];
   logic [4:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [31:0] mem_seen [32];

   program_loader #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .load_start (load_start),
      .im_we      (im_we),
      .im_waddr   (im_waddr),
      .im_wdata   (im_wdata),
      .loading    (loading),
      .load_done  (load_done),
      .load_err   (load_err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xor_all();
      logic [7:0] x = 8'h00;
      foreach (m_data[i]) x ^= m_data[i];
      return x;
   endfunction

   task automatic m_start();
      m_phase = 1;
      m_data.delete();
   endtask

   task automatic m_reset();
      m_phase = 0;
      m_data.delete();
   endtask

   task automatic m_byte(input logic [7:0] b, input logic ok);
      int sz;
      if (m_phase >= 1 && m_phase <= 3 && !ok) begin
         m_phase = 5;
         return;
      end
      case (m_phase)
         1: begin
            if (b == 0 || b > 32) m_phase = 5;
            else begin
               m_n = int'(b);
               m_phase = 2;
            end
         end
         2: begin
            m_data.push_back(b);
            sz = m_data.size();
            if (sz % 4 == 0) begin
               exp_addr.push_back(5'(sz / 4 - 1));
               exp_data.push_back({m_data[sz-1], m_data[sz-2], m_data[sz-3], m_data[sz-4]});
               if (sz / 4 == m_n) m_phase = 3;
            end
         end
         3: m_phase = (b == xor_all()) ? 4 : 5;
         default: ;
      endcase
   endtask

   // every write strobe must match the next write the model predicts
   always @(negedge clk) begin
      if (!reset && im_we) begin
         mem_seen[im_waddr] = im_wdata;
         if (exp_addr.size() == 0) chk("unexpected_write_addr", {27'd0, im_waddr}, 32'hFFFF_FFFF);
         else begin
            chk("write_addr", {27'd0, im_waddr}, {27'd0, exp_addr.pop_front()});
            chk("write_data", im_wdata, exp_data.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      m_byte(b, stop_ok);
      rx = 1'b0;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(posedge clk);
         #1;
      end
      rx = stop_ok;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 load_start = 1'b1;
      @(posedge clk);
      #1 load_start = 1'b0;
      m_start();
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      chk({tag, "_loading"}, {31'd0, loading}, {31'd0, (m_phase >= 1 && m_phase <= 3)});
      chk({tag, "_done"}, {31'd0, load_done}, {31'd0, (m_phase == 4)});
      chk({tag, "_err"}, {31'd0, load_err}, {31'd0, (m_phase == 5)});
      chk({tag, "_word_count"}, {26'd0, word_count}, 32'(m_data.size() / 4));
      chk({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_we"}, {31'd0, im_we}, 32'd0);
      chk({tag, "_waddr"}, {27'd0, im_waddr}, 32'd0);
      chk({tag, "_wdata"}, im_wdata, 32'd0);
      chk({tag, "_loading"}, {31'd0, loading}, 32'd0);
      chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
      chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
      chk({tag, "_word_count"}, {26'd0, word_count}, 32'd0);
   endtask

   task automatic send_frame(input logic [7:0] n, input logic [7:0] bytes[$], input logic [7:0] chk_b);
      send_byte(n, 1'b1);
      foreach (bytes[i]) send_byte(bytes[i], 1'b1);
      send_byte(chk_b, 1'b1);
   endtask

   initial begin
      logic [7:0] good[$];
      logic [7:0] frame[$];
      logic [7:0] x;
      int n;

      good = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h00};
      #23;
      check_zero("reset");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // bytes while idle are ignored
      send_byte(8'h02, 1'b1);
      send_byte(8'h13, 1'b1);
      check_status("idle");

      // good load
      pulse_start();
      check_status("armed");
      send_frame(8'd2, good, 8'hC1);
      check_status("good");
      chk("good_mem0", mem_seen[0], 32'h0050_0013);
      chk("good_mem1", mem_seen[1], 32'h0031_00B3);
      chk("good_done_lit", {31'd0, load_done}, 32'd1);
      chk("good_wc_lit", {26'd0, word_count}, 32'd2);

      // bad checksum
      pulse_start();
      send_frame(8'd2, good, 8'hC0);
      check_status("badchk");
      chk("badchk_err_lit", {31'd0, load_err}, 32'd1);

      // illegal counts
      pulse_start();
      send_byte(8'd0, 1'b1);
      check_status("n0");
      pulse_start();
      send_byte(8'd33, 1'b1);
      check_status("n33");
      chk("n33_loading_lit", {31'd0, loading}, 32'd0);

      // framing error on 3rd data byte
      pulse_start();
      send_byte(8'd2, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h50, 1'b0);
      for (int i = 3; i < 8; i++) send_byte(good[i], 1'b1);
      send_byte(8'hC1, 1'b1);
      check_status("ferr");

      // restart mid-frame, then a full one-word frame
      pulse_start();
      send_byte(8'd4, 1'b1);
      for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b1);
      pulse_start();
      check_status("restart_armed");
      frame = '{8'h44, 8'h33, 8'h22, 8'h11};
      send_frame(8'd1, frame, 8'h44);
      check_status("restart");
      chk("restart_mem0", mem_seen[0], 32'h1122_3344);
      chk("restart_wc_lit", {26'd0, word_count}, 32'd1);

      // asynchronous reset mid-DATA
      pulse_start();
      send_byte(8'd2, 1'b1);
      for (int i = 0; i < 5; i++) send_byte(good[i], 1'b1);
      chk("pre_reset_wc", {26'd0, word_count}, 32'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_zero("mid_reset");
      m_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 5; i < 8; i++) send_byte(good[i], 1'b1);
      send_byte(8'hC1, 1'b1);
      check_status("post_reset");

      // random frames, some with a corrupted checksum
      for (int f = 0; f < 5; f++) begin
         n = $urandom_range(1, 4);
         frame.delete();
         x = 8'h00;
         for (int i = 0; i < 4 * n; i++) begin
            frame.push_back(8'($urandom_range(0, 255)));
            x ^= frame[i];
         end
         if ($urandom_range(0, 2) == 0) x ^= 8'(1 << $urandom_range(0, 7));
         pulse_start();
         send_frame(8'(n), frame, x);
         check_status("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
